// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: shared types and default geometry for the single-NAND
// microsequencer.
//   nand_seq_state_t : sequencer state (IDLE / RUN / DONE)
//   nand_seq_instr_t : instruction layout {src_a, src_b, dst} for the
//                      default geometry (8 slots -> 3-bit indices)
//   SLOTS_DEF/STEPS_DEF : default register-file and program depths
package nand_seq_pkg;

   localparam int unsigned SLOTS_DEF = 8;
   localparam int unsigned STEPS_DEF = 16;
   localparam int unsigned IDX_W_DEF = $clog2(SLOTS_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nand_seq_state_t;

   typedef struct packed {
      logic [IDX_W_DEF-1:0] src_a;
      logic [IDX_W_DEF-1:0] src_b;
      logic [IDX_W_DEF-1:0] dst;
   } nand_seq_instr_t;

endpackage

// File: rtl/g_NAND.sv
// g_NAND: 2-input NAND cell of the gate-level logic layer.
//   a, b : operands
//   y    : ~(a & b)
module g_NAND (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = ~(a & b);

endmodule

// File: rtl/nand_seq_progmem.sv
// nand_seq_progmem: instruction store for nand_seq.
//   clk     : write clock
//   we      : write strobe (already qualified by the sequencer state)
//   wr_addr : write address
//   wr_data : instruction word written on the rising edge
//   rd_addr : read address (program counter)
//   rd_data : instruction at rd_addr, combinational read
// Contents have no reset: they survive a sequencer reset.
module nand_seq_progmem #(
   parameter int unsigned STEPS = 16,
   parameter int unsigned WIDTH = 9,
   parameter int unsigned AW    = $clog2(STEPS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [STEPS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nand_seq.sv
// nand_seq: single-NAND microsequencer. Runs a stored list of
// slot[dst] <= NAND(slot[src_a], slot[src_b]) operations, one per cycle,
// through one shared g_NAND cell.
//   clk_sys   : clock
//   reset_n   : synchronous active-low reset
//   start     : run request, sampled in IDLE only
//   step      : (NAND_SEQ_STEP_EN only) RUN advances only when high
//   in_vec    : initial slot contents, latched on accepted start
//   prog_len  : steps to run, latched on accepted start, clamped to STEPS
//   prog_we   : program write strobe, honoured in IDLE only
//   prog_addr : program write address
//   prog_data : instruction {src_a, src_b, dst}
//   busy      : state is not IDLE
//   done      : one-cycle completion pulse
//   out_vec   : slot register file
// Optional feature macro: NAND_SEQ_STEP_EN.
module nand_seq
   import nand_seq_pkg::*;
#(
   parameter int unsigned SLOTS = SLOTS_DEF,
   parameter int unsigned STEPS = STEPS_DEF,
   localparam int unsigned IDX_W = $clog2(SLOTS),
   localparam int unsigned PC_W  = $clog2(STEPS)
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic               start,
`ifdef NAND_SEQ_STEP_EN
   input  logic               step,
`endif
   input  logic [SLOTS-1:0]   in_vec,
   input  logic [PC_W:0]      prog_len,
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [3*IDX_W-1:0] prog_data,
   output logic               busy,
   output logic               done,
   output logic [SLOTS-1:0]   out_vec
);

   nand_seq_state_t state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W:0]      len_q, len_d;
   logic [SLOTS-1:0]   slots_q, slots_d;

   logic [3*IDX_W-1:0] instr;
   logic [IDX_W-1:0]   src_a, src_b, dst;
   logic               op_a, op_b, nand_y;
   logic [PC_W:0]      len_clamp;
   logic               advance;
   logic               last_step;

   nand_seq_progmem #(
      .STEPS (STEPS),
      .WIDTH (3*IDX_W)
   ) u_progmem (
      .clk     (clk_sys),
      .we      (prog_we && (state_q == IDLE)),
      .wr_addr (prog_addr),
      .wr_data (prog_data),
      .rd_addr (pc_q),
      .rd_data (instr)
   );

   assign src_a = instr[3*IDX_W-1 -: IDX_W];
   assign src_b = instr[2*IDX_W-1 -: IDX_W];
   assign dst   = instr[IDX_W-1:0];

   // Operands come from the registered slots, so dst aliasing a source
   // still sees the pre-edge value.
   assign op_a = slots_q[src_a];
   assign op_b = slots_q[src_b];

   g_NAND u_nand (
      .a (op_a),
      .b (op_b),
      .y (nand_y)
   );

   assign len_clamp = (prog_len > (PC_W+1)'(STEPS)) ? (PC_W+1)'(STEPS) : prog_len;
   assign last_step = (({1'b0, pc_q} + (PC_W+1)'(1)) == len_q);

`ifdef NAND_SEQ_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      slots_d = slots_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               slots_d = in_vec;
               pc_d    = '0;
               len_d   = len_clamp;
               state_d = (len_clamp == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (advance) begin
               slots_d[dst] = nand_y;
               if (last_step) begin
                  state_d = DONE;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         slots_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         slots_q <= slots_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign out_vec = slots_q;

endmodule

// File: doc/nand_seq.md
# nand_seq

Single-NAND microsequencer for the gate-level logic layer. Evaluates a small stored netlist of 2-input NAND operations over an 8-slot bit register file, one operation per cycle, through exactly one shared `g_NAND` cell. This lets derived gates (NOT/AND/OR/NOR/XOR) be computed serially for demonstration and self-test without instantiating one NAND per node.

## Interface
- `SLOTS`, 8: bit slots in the register file; power of two, 2..16; `IDX_W = $clog2(SLOTS)`.
- `STEPS`, 16: program memory depth; power of two; `PC_W = $clog2(STEPS)`.
- `clk_sys  in  1`: single clock; all state changes on its rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `start  in  1`: run request; sampled only in IDLE.
- `in_vec  in  SLOTS`: initial slot contents, latched on accepted start.
- `prog_len  in  PC_W+1`: steps to execute, latched on accepted start; values > STEPS clamp to STEPS.
- `prog_we  in  1`: program write strobe.
- `prog_addr  in  PC_W`: program write address.
- `prog_data  in  3*IDX_W`: instruction `{src_a, src_b, dst}`, with `src_a` in the MSBs.
- `busy  out  1`: high whenever the state is not IDLE.
- `done  out  1`: one-cycle pulse on completion.
- `out_vec  out  SLOTS`: slot register file, registered.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:**
  - `start=1` with latched length L ≥ 1: slots ← `in_vec`, pc ← 0, go to RUN.
  - `start=1` with L = 0: slots ← `in_vec`, go straight to DONE.
- **RUN:** each cycle executes `prog[pc]`: `slot[dst] ← NAND(slot[src_a], slot[src_b])`, with both operands read from pre-edge values. If pc == L−1, go to DONE; otherwise pc ← pc+1.
- **DONE:** `done=1` for this cycle only, then return to IDLE.
- `dst` equal to `src_a` or `src_b` is legal; the old value is used as the operand.
- `start` is ignored while busy; it is not queued.
- `prog_we` is honoured in IDLE only. Writes in RUN or DONE are dropped so the program cannot change mid-run.
- `out_vec` holds its value from DONE until the next accepted start.
- **Reset:**
  - `busy=0`, `done=0`, `out_vec=0`, pc=0, state=IDLE.
  - Reset mid-run aborts immediately, with no `done` pulse.
  - Program memory is not reset; it is retained across reset and undefined after power-up.

## Timing
- Start is sampled at edge T, with length L.
- `busy` is high in cycles T+1 … T+L+1.
- Step k executes in cycle T+1+k; its result is visible on `out_vec` from cycle T+2+k.
- `done` is high in cycle T+L+1.
- A new start is accepted at the earliest in cycle T+L+2.
- L = 0: `done` in cycle T+1, `out_vec = in_vec`.
- A program write at edge W is readable by a run started at edge W+1 or later.

## Configuration
- `NAND_SEQ_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - RUN executes and advances only in cycles with `step=1`; otherwise it holds state.
  - DONE and IDLE are unaffected.
- Undefined: no `step` port; RUN advances every cycle.

## Structure
- Package `nand_seq_pkg` holds:
  - `nand_seq_state_t` enum (IDLE/RUN/DONE).
  - `nand_seq_instr_t` packed struct `{src_a, src_b, dst}`.
  - Default `SLOTS`/`STEPS` localparams.
- Sub-module `nand_seq_progmem`: STEPS × 3·IDX_W register array, one synchronous write port, one asynchronous read port addressed by pc.
- The existing `g_NAND` is instantiated exactly once as the sole logic evaluator.

## Test plan
- **NOR, a=0 b=0.** Program: 0:{0,0,2} 1:{1,1,3} 2:{2,3,4} 3:{4,4,5}, L=4, `in_vec`=0x00 → `done` at T+5, `out_vec`=0x2C (slot5=1).
- **NOR, a=1 b=0.** Same program, `in_vec`=0x01 → `out_vec`=0x19 (slot5=0).
- **Zero length.** L=0, `in_vec`=0xA5 → `done` at T+1, `busy` high one cycle only, `out_vec`=0xA5.
- **Busy protection.** During the NOR run, pulse `start` at T+2 and write `prog_addr`=3 with {0,0,5} → both ignored; result matches the first test; a later run also matches.
- **Reset mid-run.** Assert `reset_n`=0 in cycle T+3 → next cycle `busy`=0, `done`=0, `out_vec`=0x00; a rerun with the original program gives 0x2C.
- **Step mode (macro defined).** NOR run with `step` pulsed every third cycle → `done` after the 4th step pulse, final `out_vec`=0x2C.
